// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Define HAZ_FWD_EN for load-use-only stalls plus EX operand forwarding.
module pipe_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwrite,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [7:0]       stall_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, MEMWAIT = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic       memwait, timeout_hit, flush, hazard;
  logic [1:0] fwd_a_d, fwd_b_d;

  // A producer only matters if it writes a non-zero register.
  function automatic logic hit(input logic we, input logic [REG_W-1:0] rd,
                               input logic [REG_W-1:0] src);
    return we && (rd != '0) && (rd == src);
  endfunction

`ifdef HAZ_FWD_EN
  assign hazard = ex_memread &&
                  (hit(ex_regwrite, ex_rd, id_rs) ||
                   (id_uses_rt && hit(ex_regwrite, ex_rd, id_rt)));

  always_comb begin
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    if (hit(mem_regwrite, mem_rd, ex_rs))     fwd_a_d = 2'b10;
    else if (hit(wb_regwrite, wb_rd, ex_rs))  fwd_a_d = 2'b01;
    if (hit(mem_regwrite, mem_rd, ex_rt))     fwd_b_d = 2'b10;
    else if (hit(wb_regwrite, wb_rd, ex_rt))  fwd_b_d = 2'b01;
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{ex_rs, ex_rt, ex_memread};

  // Without forwarding the ID reader waits until the producer has retired from WB.
  assign hazard = hit(ex_regwrite, ex_rd, id_rs) || hit(mem_regwrite, mem_rd, id_rs) ||
                  hit(wb_regwrite, wb_rd, id_rs) ||
                  (id_uses_rt && (hit(ex_regwrite, ex_rd, id_rt) ||
                                  hit(mem_regwrite, mem_rd, id_rt) ||
                                  hit(wb_regwrite, wb_rd, id_rt)));
  assign fwd_a_d = 2'b00;
  assign fwd_b_d = 2'b00;
`endif

  assign memwait     = dmem_req && !dmem_ready;
  assign timeout_hit = memwait && (state_q == MEMWAIT) &&
                       (wait_cnt_q == 8'(MEM_TIMEOUT - 1));
  assign flush       = ex_branch_taken || ex_jump;

  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    exmem_hold    = 1'b0;
    state_d       = RUN;
    wait_cnt_d    = '0;
    stall_cnt_d   = '0;
    mem_timeout_d = mem_timeout_q;
    if (memwait && !timeout_hit) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_hold  = 1'b1;
      state_d     = MEMWAIT;
      wait_cnt_d  = (state_q == MEMWAIT) ? wait_cnt_q + 8'd1 : 8'd1;
      stall_cnt_d = stall_cnt_q;
    end else begin
      // A timed-out access is released and the pipeline resumes its normal decision.
      if (timeout_hit) mem_timeout_d = 1'b1;
      if (flush) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (hazard) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        state_d     = STALL;
        stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;
      end
    end
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_hold  = 1'b0;
    end
  end

  assign fwd_a       = rst_n ? fwd_a_d : 2'b00;
  assign fwd_b       = rst_n ? fwd_b_d : 2'b00;
  assign stall_cnt   = stall_cnt_q;
  assign mem_timeout = mem_timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Decides each cycle whether PC / IF-ID advance, whether the ID-EX register loads a bubble (all control bits zero), and whether the EX-MEM register holds.
- Covers load-use and RAW stalls, branch/jump squash, and data-memory wait states.
- Sits beside the ID-EX pipeline register and drives its bubble and the neighbouring write-enables.

Parameters:
- REG_W, 5, register-specifier width.
- MEM_TIMEOUT, 16, maximum consecutive MEMWAIT cycles before forced exit; legal range 2..255.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  REG_W  rs of instruction in ID
- id_rt  in  REG_W  rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_rs  in  REG_W  rs of instruction in EX
- ex_rt  in  REG_W  rt of instruction in EX
- ex_rd  in  REG_W  destination in EX (after RegDst mux)
- ex_regwrite  in  1  EX RegWrite
- ex_memread  in  1  EX MemRead
- ex_branch_taken  in  1  branch resolved taken in EX
- ex_jump  in  1  EX ControlJump
- mem_rd  in  REG_W  destination in MEM
- mem_regwrite  in  1  MEM RegWrite
- wb_rd  in  REG_W  destination in WB
- wb_regwrite  in  1  WB RegWrite
- dmem_req  in  1  MEM stage access in progress
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF-ID load enable
- ifid_flush  out  1  IF-ID loads NOP
- idex_bubble  out  1  ID-EX loads zero controls
- exmem_hold  out  1  EX-MEM and MEM-WB hold
- fwd_a  out  2  EX operand A select: 00 regfile, 10 EX-MEM, 01 MEM-WB
- fwd_b  out  2  EX operand B select, same encoding
- stall_cnt  out  8  consecutive data-stall cycles, saturating
- mem_timeout  out  1  sticky timeout flag

Behaviour:
- Registered state: RUN=0, STALL=1, MEMWAIT=2. Also registered: wait counter (8 bit), stall_cnt, mem_timeout. All other outputs are combinational from state and inputs.
- While rst_n=0 (asynchronous):
  - state=RUN, counters=0, mem_timeout=0.
  - Outputs: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_hold=0, fwd_a=fwd_b=00.
- Register 0 never creates a hazard or a forward.
- Priority each cycle: memwait > flush > data stall > run.
- memwait condition (dmem_req & !dmem_ready):
  - pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0, exmem_hold=1.
  - Next state MEMWAIT; wait counter +1.
- Wait counter reaching MEM_TIMEOUT-1 while still waiting:
  - mem_timeout set (sticky until reset), counter cleared, next state RUN.
  - exmem_hold=0 that cycle.
- dmem_ready=1 in MEMWAIT: counter cleared, next state RUN; the normal decision applies in the same cycle.
- flush condition (ex_branch_taken | ex_jump, no memwait):
  - ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
  - Any simultaneous data hazard is discarded; stall_cnt cleared; next state RUN.
- Data hazard (no memwait, no flush):
  - pc_write=0, ifid_write=0, idex_bubble=1; next state STALL; stall_cnt +1, saturating at 255.
- Otherwise: pc_write=1, ifid_write=1, all else 0, next state RUN, stall_cnt cleared.
- Data stall lasts until the hazard expression drops; no fixed length.

Optional Feature:
- Macro: HAZ_FWD_EN.
- With the macro:
  - Hazard = ex_memread & ex_regwrite & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)). Load-use stall is exactly 1 cycle.
  - fwd_a = 10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs; else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs; else 00.
  - fwd_b uses the same rules with ex_rt.
- Without the macro:
  - Hazard = any of the EX, MEM or WB producers (regwrite=1, rd!=0) matching id_rs, or id_rt when id_uses_rt=1. RAW stall is up to 3 cycles.
  - fwd_a and fwd_b are tied to 00.

Test Plan:
- Reset: assert rst_n=0 mid-STALL -> outputs immediately at reset values; after release with no hazard, pc_write=1, stall_cnt=0.
- Load-use (HAZ_FWD_EN): EX lw with ex_rd=8, ID add with rs=8 -> exactly 1 cycle of pc_write=0, idex_bubble=1, stall_cnt=1; next cycle fwd_a=01.
- No-forward RAW: EX add rd=9, ID rs=9 -> 3 stall cycles as the producer moves EX->MEM->WB; stall_cnt reaches 3, then RUN.
- Flush beats stall: ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_bubble=1, pc_write=1, stall_cnt=0.
- Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles, then 1 -> exmem_hold=1 for 4 cycles, no bubble, then RUN.
- Timeout: dmem_ready held 0 with MEM_TIMEOUT=16 -> exit on the 16th cycle, mem_timeout=1 and stays 1 until rst_n=0.
